fully_connected_mem: RTL and testbench

Parallel weight store for the fully-connected (dense) layer of the CNN datapath. It holds one signed/unsigned weight word per element of the flattened feature vector (FLATTENED_LENGTH words). All words are loaded in a single clock when write-enabled and presented continuously, in parallel, to the fully-connected MAC stage.

---
 rtl/fully_connected_mem.sv | 37 +++
 tb/tb_fully_connected_mem.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fully_connected_mem.sv
// Parallel weight store for the dense layer: every word loads in one clock
// when write-enabled and is presented continuously to the MAC stage.
module fully_connected_mem #(
  parameter int FLATTENED_LENGTH          = 50,
  parameter int FULLYCONNECTED_DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fullyconnected_WrEn,
  input  logic [FULLYCONNECTED_DATA_WIDTH-1:0] fullyconnected_weights_input  [FLATTENED_LENGTH],
  output logic [FULLYCONNECTED_DATA_WIDTH-1:0] fullyconnected_weights_output [FLATTENED_LENGTH]
);

  logic [FULLYCONNECTED_DATA_WIDTH-1:0] mem_q [FLATTENED_LENGTH];
  logic [FULLYCONNECTED_DATA_WIDTH-1:0] mem_d [FLATTENED_LENGTH];

  // Whole-array load only; there is no per-word write path.
  always_comb begin
    mem_d = mem_q;
    if (fullyconnected_WrEn) begin
      mem_d = fullyconnected_weights_input;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FLATTENED_LENGTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign fullyconnected_weights_output = mem_q;

endmodule

// File: tb/tb_fully_connected_mem.sv
// Randomized self-checking bench for fully_connected_mem against an
// array-level model of the weight store.
module tb_fully_connected_mem;

  localparam int N = 50;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wren = 1'b0;
  logic [W-1:0] din   [N];
  logic [W-1:0] dout  [N];
  logic [W-1:0] model [N];
  logic [W-1:0] pat   [N];

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  fully_connected_mem #(
    .FLATTENED_LENGTH          (N),
    .FULLYCONNECTED_DATA_WIDTH (W)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .fullyconnected_WrEn           (wren),
    .fullyconnected_weights_input  (din),
    .fullyconnected_weights_output (dout)
  );

  task automatic check_lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_output(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      if (bad < 0 && dout[i] !== model[i]) bad = i;
    end
    checks++;
    if (bad < 0) passed++;
    else $display("[TB] FAIL %s @%0t: word %0d got %0h, expected %0h",
                  name, $time, bad, dout[bad], model[bad]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  // Drive one cycle's inputs away from both edges, then apply the storage rule
  // to the model at the following rising edge.
  task automatic apply_stimulus(input logic r, input logic we);
    @(negedge clk);
    #2;
    din  = pat;
    rst  = r;
    wren = we;
    if (!r) clear_model();
    @(posedge clk);
    if (rst && wren) model = din;
  endtask

  always @(negedge clk) begin
    if (cmp_en) check_output("cycle_compare");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pat[i]   = W'(i);
      din[i]   = W'(i);
      model[i] = '0;
    end
    wren = 1'b1;
    #1 rst = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset dominates write enable
    repeat (3) apply_stimulus(1'b0, 1'b1);
    #1;
    check_lit("reset_word0", dout[0], 8'h00);
    check_lit("reset_word49", dout[49], 8'h00);

    // Single write, visible right after the edge
    apply_stimulus(1'b1, 1'b1);
    #1;
    check_lit("write_word0", dout[0], 8'd0);
    check_lit("write_word49", dout[49], 8'd49);
    check_lit("model_pin_49", model[49], 8'd49);

    // Hold with changed inputs
    for (int i = 0; i < N; i++) pat[i] = W'(255 - i);
    repeat (5) apply_stimulus(1'b1, 1'b0);
    #1;
    check_lit("hold_word10", dout[10], 8'd10);
    check_lit("hold_word49", dout[49], 8'd49);

    // Back-to-back overwrites
    for (int i = 0; i < N; i++) pat[i] = 8'hA5;
    apply_stimulus(1'b1, 1'b1);
    #1;
    check_lit("over_a5_word17", dout[17], 8'hA5);
    for (int i = 0; i < N; i++) pat[i] = 8'h5A;
    apply_stimulus(1'b1, 1'b1);
    #1;
    check_lit("over_5a_word17", dout[17], 8'h5A);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b0;
    clear_model();
    #1;
    check_lit("async_word0", dout[0], 8'h00);
    check_lit("async_word49", dout[49], 8'h00);
    for (int i = 0; i < N; i++) pat[i] = W'($urandom);
    repeat (2) apply_stimulus(1'b1, 1'b0);
    #1;
    check_lit("post_reset_word3", dout[3], 8'h00);

    // Width extremes and index isolation
    for (int i = 0; i < N; i++) pat[i] = 8'h80;
    pat[0]  = 8'hFF;
    pat[49] = 8'h00;
    apply_stimulus(1'b1, 1'b1);
    #1;
    check_lit("ext_word0", dout[0], 8'hFF);
    check_lit("ext_word1", dout[1], 8'h80);
    check_lit("ext_word48", dout[48], 8'h80);
    check_lit("ext_word49", dout[49], 8'h00);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) pat[i] = W'($urandom);
      apply_stimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
